// File: rtl/avalon_conv_engine_if.sv
// Avalon-MM slave bus bundle for avalon_conv_engine.
// The host side drives strobes, address and write data; the engine returns read data.
interface avalon_conv_engine_if #(
  parameter int ADDR_W = 6
) ();
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic              AVL_CS;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA;
  logic [31:0]       AVL_READDATA;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/avalon_conv_engine.sv
// Register-mapped KxK convolution engine: one shared multiplier, one tap per cycle, per-channel argmax.
// Optional macro CONV_RELU_EN clamps stored results (and the argmax comparison) at zero.
module avalon_conv_engine #(
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int NCH    = 4,
  parameter int ADDR_W = 6
) (
  input  logic                   CLK,
  input  logic                   RESET,
  avalon_conv_engine_if.slave    avl,
  output logic [31:0]            EXPORT_DATA
);
  localparam int T     = K * K;
  localparam int ACC_W = 2 * DW + $clog2(T);
  localparam int TW    = (T > 1) ? $clog2(T) : 1;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int KW    = ((NCH * T) > 1) ? $clog2(NCH * T) : 1;
  localparam logic [ADDR_W-1:0] A_KER  = ADDR_W'(T);
  localparam logic [ADDR_W-1:0] A_RB   = ADDR_W'(T * (NCH + 1));
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(T * (NCH + 1) + NCH);
  localparam logic [ADDR_W-1:0] A_ARG  = ADDR_W'(T * (NCH + 1) + NCH + 1);

  typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;

  logic signed [DW-1:0]    pix_mem [T];
  logic signed [DW-1:0]    ker_mem [NCH*T];
  logic [31:0]             res_mem [NCH];
  state_t                  state_reg;
  logic [TW-1:0]           t_reg;
  logic [CW-1:0]           c_reg;
  logic [KW-1:0]           k_ptr_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] best_reg;
  logic [7:0]              argmax_reg;
  logic                    done_reg;
  logic                    busy_reg;
  logic [31:0]             rdata_reg;

  logic                    wr_en, ctrl_wr, start, clear, pix_we, ker_we;
  logic [ADDR_W-1:0]       ker_off, res_off;
  logic [DW-1:0]           wmask;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] store_val;
  logic [31:0]             rd_value;
  logic                    unused_bits;

  assign wr_en   = avl.AVL_CS & avl.AVL_WRITE;
  assign ctrl_wr = wr_en & (avl.AVL_ADDR == A_CTRL) & avl.AVL_BYTE_EN[0];
  assign start   = ctrl_wr & avl.AVL_WRITEDATA[0];
  assign clear   = ctrl_wr & avl.AVL_WRITEDATA[1];
  assign pix_we  = wr_en & ~busy_reg & (avl.AVL_ADDR < A_KER);
  assign ker_we  = wr_en & ~busy_reg & (avl.AVL_ADDR >= A_KER) & (avl.AVL_ADDR < A_RB);
  assign ker_off = avl.AVL_ADDR - A_KER;
  assign res_off = avl.AVL_ADDR - A_RB;
  assign unused_bits = ^{avl.AVL_WRITEDATA, avl.AVL_BYTE_EN, ker_off, res_off};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW; b++) wmask[b] = avl.AVL_BYTE_EN[b/8];
  end

  // Input storage is frozen while a run is in progress so taps stay consistent.
  generate
    for (genvar gi = 0; gi < T; gi++) begin : g_pix
      always_ff @(posedge CLK) begin
        if (RESET) pix_mem[gi] <= '0;
        else if (pix_we && avl.AVL_ADDR == ADDR_W'(gi))
          pix_mem[gi] <= (pix_mem[gi] & ~wmask) | (avl.AVL_WRITEDATA[DW-1:0] & wmask);
      end
    end
    for (genvar gi = 0; gi < NCH * T; gi++) begin : g_ker
      always_ff @(posedge CLK) begin
        if (RESET) ker_mem[gi] <= '0;
        else if (ker_we && ker_off[KW-1:0] == KW'(gi))
          ker_mem[gi] <= (ker_mem[gi] & ~wmask) | (avl.AVL_WRITEDATA[DW-1:0] & wmask);
      end
    end
  endgenerate

  assign prod = pix_mem[t_reg] * ker_mem[k_ptr_reg];

  always_comb begin
`ifdef CONV_RELU_EN
    store_val = acc_reg[ACC_W-1] ? '0 : acc_reg;
`else
    store_val = acc_reg;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      t_reg      <= '0;
      c_reg      <= '0;
      k_ptr_reg  <= '0;
      acc_reg    <= '0;
      best_reg   <= '0;
      argmax_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      for (int i = 0; i < NCH; i++) res_mem[i] <= '0;
    end else begin
      if (clear) done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            done_reg   <= 1'b0;
            t_reg      <= '0;
            c_reg      <= '0;
            k_ptr_reg  <= '0;
            acc_reg    <= '0;
            argmax_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
          if (!(t_reg == TW'(T-1) && c_reg == CW'(NCH-1))) k_ptr_reg <= k_ptr_reg + 1'b1;
          if (t_reg == TW'(T-1)) state_reg <= STORE;
          else                   t_reg     <= t_reg + 1'b1;
        end
        STORE: begin
          res_mem[c_reg] <= 32'(store_val);
          // Strictly-greater compare keeps the lowest index on ties.
          if (c_reg == '0 || store_val > best_reg) begin
            best_reg   <= store_val;
            argmax_reg <= 8'(c_reg);
          end
          acc_reg <= '0;
          t_reg   <= '0;
          if (c_reg == CW'(NCH-1)) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            c_reg     <= c_reg + 1'b1;
            state_reg <= MAC;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    if (avl.AVL_ADDR < A_KER)
      rd_value = 32'(pix_mem[avl.AVL_ADDR[TW-1:0]]);
    else if (avl.AVL_ADDR < A_RB)
      rd_value = 32'(ker_mem[ker_off[KW-1:0]]);
    else if (avl.AVL_ADDR < A_CTRL)
      rd_value = res_mem[res_off[CW-1:0]];
    else if (avl.AVL_ADDR == A_CTRL)
      rd_value = {30'd0, done_reg, busy_reg};
    else if (avl.AVL_ADDR == A_ARG)
      rd_value = {24'd0, argmax_reg};
  end

  always_ff @(posedge CLK) begin
    if (RESET) rdata_reg <= '0;
    else       rdata_reg <= (avl.AVL_CS & avl.AVL_READ) ? rd_value : '0;
  end

  assign avl.AVL_READDATA = rdata_reg;
  assign EXPORT_DATA      = {done_reg, busy_reg, 22'd0, argmax_reg};
endmodule

// File: tb/tb_avalon_conv_engine.sv
// Self-checking bench for avalon_conv_engine: table-driven runs, a random run against a
// dot-product model, and hand sequences for byte enables, busy-time writes and mid-run reset.
module tb_avalon_conv_engine;
  localparam int K = 3, T = 9, NCH = 4, DW = 8, ADDR_W = 6;
  localparam int RB = 45, CTRL = 49, ARG = 50;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] EXPORT_DATA;

  avalon_conv_engine_if #(.ADDR_W(ADDR_W)) avl ();

  avalon_conv_engine #(.K(K), .DW(DW), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .avl(avl), .EXPORT_DATA(EXPORT_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  typedef struct { string name; int pix; int ker[NCH]; int res[NCH]; int arg; } vec_t;
  vec_t vecs[4];

  logic signed [7:0] pix_m [T];
  logic signed [7:0] ker_m [NCH*T];
  int                res_m [NCH];
  int                arg_m;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    avl.AVL_BYTE_EN = 4'h0; avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0;
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] be);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = ADDR_W'(a);
    avl.AVL_WRITEDATA = d; avl.AVL_BYTE_EN = be;
    tick();
    idle_bus();
  endtask

  task automatic rd(int a, logic [31:0] exp, string name);
    sb_t e;
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = ADDR_W'(a);
    sb_q.push_back('{name, exp});
    tick();
    idle_bus();
    e = sb_q.pop_front();
    check(e.name, avl.AVL_READDATA, e.exp);
  endtask

  function automatic int exp_res(int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_run;
    int acc, best;
    best = 0;
    for (int c = 0; c < NCH; c++) begin
      acc = 0;
      for (int t = 0; t < T; t++) acc += int'(pix_m[t]) * int'(ker_m[c*T+t]);
      acc = exp_res(acc);
      res_m[c] = acc;
      if (c == 0 || acc > best) begin
        best = acc;
        arg_m = c;
      end
    end
  endtask

  task automatic load_all;
    for (int t = 0; t < T; t++) wr(t, 32'(pix_m[t]), 4'hF);
    for (int i = 0; i < NCH*T; i++) wr(T + i, 32'(ker_m[i]), 4'hF);
  endtask

  task automatic wait_done(int start_cyc, string name);
    int guard = 0;
    while (EXPORT_DATA[30] && guard < 500) begin
      tick();
      guard++;
    end
    if (EXPORT_DATA[30]) begin
      total++;
      bad++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, guard);
    end else begin
      check({name, " busy_cycles"}, 32'(cyc - start_cyc), 32'd40);
    end
  endtask

  task automatic run_and_check(string name);
    int s;
    load_all();
    wr(CTRL, 32'h1, 4'h1);
    s = cyc;
    check({name, " busy_after_start"}, {31'd0, EXPORT_DATA[30]}, 32'd1);
    wait_done(s, name);
    check({name, " export"}, EXPORT_DATA, {1'b1, 1'b0, 22'd0, 8'(arg_m)});
    for (int c = 0; c < NCH; c++) rd(RB + c, res_m[c], $sformatf("%s res%0d", name, c));
    rd(ARG, arg_m, {name, " argmax"});
    rd(CTRL, 32'h2, {name, " ctrl"});
  endtask

  initial begin
    int s;
    vecs[0] = '{"ones",    1,   '{1, 2, 3, 4},           '{9, 18, 27, 36},                   3};
    vecs[1] = '{"extreme", -128, '{-128, 127, 0, 0},     '{147456, -146304, 0, 0},           0};
    vecs[2] = '{"tie",     2,   '{-1, 5, 5, -3},         '{-18, 90, 90, -54},                1};
    vecs[3] = '{"allneg",  127, '{-128, -128, -128, -128}, '{-146304, -146304, -146304, -146304}, 0};

    idle_bus();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    check("reset export", EXPORT_DATA, 32'h0);
    check("reset readdata", avl.AVL_READDATA, 32'h0);
    for (int a = 0; a < 64; a++) rd(a, 32'h0, $sformatf("reset addr%0d", a));

    // Byte enables and sign extension on pixel 0.
    wr(0, 32'hFFFF_FF05, 4'h1);
    rd(0, 32'h5, "be 0001");
    wr(0, 32'hFFFF_FF77, 4'h0);
    rd(0, 32'h5, "be 0000");
    wr(0, 32'h0000_0080, 4'h1);
    rd(0, 32'hFFFF_FF80, "sign extend");
    wr(RB, 32'h1234, 4'hF);
    rd(RB, 32'h0, "result ro");
    wr(60, 32'h1234, 4'hF);
    rd(60, 32'h0, "unmapped");

    for (int v = 0; v < 4; v++) begin
      for (int t = 0; t < T; t++) pix_m[t] = 8'(vecs[v].pix);
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < T; t++) ker_m[c*T+t] = 8'(vecs[v].ker[c]);
      for (int c = 0; c < NCH; c++) res_m[c] = exp_res(vecs[v].res[c]);
      arg_m = vecs[v].arg;
      run_and_check(vecs[v].name);
    end

    for (int t = 0; t < T; t++) pix_m[t] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NCH*T; i++) ker_m[i] = 8'($urandom_range(0, 255));
    model_run();
    run_and_check("rand");

    // Writes during busy: pixel dropped, restart ignored, clear-done harmless.
    wr(CTRL, 32'h1, 4'h1);
    s = cyc;
    wr(0, 32'(~pix_m[0]), 4'hF);
    rd(0, 32'(pix_m[0]), "busy pixel write dropped");
    wr(CTRL, 32'h1, 4'h1);
    wr(CTRL, 32'h2, 4'h1);
    rd(CTRL, 32'h1, "busy ctrl");
    wait_done(s, "restart");
    rd(RB, res_m[0], "restart res0");
    rd(CTRL, 32'h2, "restart done");
    wr(CTRL, 32'h2, 4'h1);
    rd(CTRL, 32'h0, "clear done");
    wr(CTRL, 32'h3, 4'h1);
    s = cyc;
    rd(CTRL, 32'h1, "start+clear");
    wait_done(s, "start+clear");
    rd(CTRL, 32'h2, "start+clear done");

    // Reset mid-run.
    wr(CTRL, 32'h1, 4'h1);
    repeat (9) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midreset export", EXPORT_DATA, 32'h0);
    rd(CTRL, 32'h0, "midreset ctrl");
    rd(RB, 32'h0, "midreset res0");
    rd(ARG, 32'h0, "midreset argmax");
    rd(0, 32'h0, "midreset pixel0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
